pipe_mem_arbiter: RTL and testbench
===================================

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, consecutive waitrequest-high cycles before timeout flag.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 if_req / if_addr  input  1/32  fetch request and word address, held until if_ack.
REQ-005 if_rdata / if_ack  output  32/1  fetched word; one-cycle completion pulse.
REQ-006 d_read / d_write / d_addr / d_byteenable / d_wdata  input  1/1/32/4/32  data-side (MEM stage) request.
REQ-007 d_rdata / d_ack  output  32/1  load data; one-cycle completion pulse.
REQ-008 mem_address / mem_read / mem_write / mem_byteenable / mem_writedata  output  32/1/1/4/32  shared memory bus.
REQ-009 mem_readdata / mem_waitrequest  input  32/1  bus read data; bus stall.
REQ-010 fetch_sel  output  1  1 = fetch owns or last owned the bus, 0 = data side.
REQ-011 if_stall / d_stall  output  1/1  requester has a pending, not yet acknowledged request.
REQ-012 proto_err / timeout  output  1/1  sticky error flags.

Function
REQ-013 FSM states IDLE, FETCH, DATA; exactly one bus transaction outstanding at any time.
REQ-014 IDLE: d_read|d_write and if_req both low -> stay IDLE, mem_read=mem_write=0.
REQ-015 IDLE grant, only data pending -> DATA; only fetch pending -> FETCH.
REQ-016 IDLE, both pending: grant opposite of last completed grant (last_grant register, reset value = FETCH, so data wins first conflict).
REQ-017 On grant, latch address, byteenable, wdata, direction; fetch byteenable = 4'b1111, fetch always read.
REQ-018 FETCH/DATA: drive mem_* from latched values every cycle until completion; values constant while mem_waitrequest=1.
REQ-019 Completion = rising edge with state FETCH/DATA and mem_waitrequest=0; at that edge latch mem_readdata (reads), update last_grant, go IDLE.
REQ-020 Ack pulses one cycle after completion edge, exactly one cycle wide; if_rdata/d_rdata hold value until next completed read of same side.
REQ-021 Minimum latency: request seen at edge N -> bus active cycle N..N+1 -> ack high cycle N+2 with zero wait states; +1 cycle per waitrequest-high cycle.
REQ-022 A request re-asserted in the ack cycle is accepted at that edge (IDLE), not double-counted; a requester holding req high through its ack cycle is treated as a new request.
REQ-023 Requester deasserting after grant does not abort; transaction completes and ack still pulses.
REQ-024 d_read and d_write both high at grant: write performed, read ignored, proto_err set.
REQ-025 Wait counter: 8+ bit, clears on grant, increments each FETCH/DATA cycle with mem_waitrequest=1, saturates; reaching TIMEOUT_CYCLES sets timeout; transaction is not aborted.
REQ-026 fetch_sel = 1 in FETCH, 0 in DATA, last_grant value in IDLE.
REQ-027 if_stall = if_req & ~if_ack; d_stall = (d_read|d_write) & ~d_ack.
REQ-028 Write transactions never update d_rdata.

Reset
REQ-029 reset_n low asynchronously forces: state IDLE, mem_read=mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0, if_ack=d_ack=0, if_rdata=d_rdata=0, last_grant=FETCH, wait counter 0, proto_err=timeout=0, fetch_sel=1.
REQ-030 Reset mid-transaction drops the bus transaction with no ack; after release the FSM resumes from IDLE at the next edge.

Verification
REQ-031 Fetch only, if_addr=0xBFC00000, waitrequest=0, readdata=0x24020005 -> mem_read one cycle at 0xBFC00000, be=4'hF; if_ack pulses 2 cycles after request; if_rdata=0x24020005.
REQ-032 Both pending after reset, data read 0x1000 and fetch 0x0004 -> data granted first (fetch_sel=0), fetch next; d_ack precedes if_ack; if_stall high throughout the data access.
REQ-033 Data write 0x2000, be=4'b0011, wdata=0xDEADBEEF, waitrequest high 3 cycles -> mem_write held 4 cycles, address/be/wdata stable; d_ack after final cycle; d_rdata unchanged.
REQ-034 Continuous d_read and if_req for 6 transactions -> grants alternate D,F,D,F,D,F; no side starves.
REQ-035 waitrequest stuck high with TIMEOUT_CYCLES=4 -> timeout set after 4 wait cycles, mem_read still asserted; d_read=d_write=1 -> proto_err set, mem_write=1.
REQ-036 reset_n low during DATA with waitrequest=1 -> mem_write drops same cycle, no d_ack; after release, pending fetch completes normally.

Source files
------------

// File: rtl/pipe_mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data) onto one shared memory bus.
// One bus transaction in flight at a time; conflicts alternate with last grant.
module pipe_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        fetch_sel,
  output logic        if_stall,
  output logic        d_stall,
  output logic        proto_err,
  output logic        timeout,
  output logic [1:0]  fsm_state
);

  // Handshake: a requester holds its request until the one-cycle ack; on the
  // bus, a transaction completes at the first edge where mem_waitrequest is low.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam int WCW = 16;

  state_t          state;
  logic            last_grant;  // 1 = fetch completed last
  logic [WCW-1:0]  wait_cnt;
  logic [WCW-1:0]  wait_nxt;
  logic            d_pend;
  logic            grant_data;

  assign d_pend     = d_read | d_write;
  // Data wins when alone, or on a conflict if fetch completed last.
  assign grant_data = d_pend && (!if_req || last_grant);

  always_comb begin
    wait_nxt = wait_cnt;
    if (!(&wait_cnt)) wait_nxt = wait_cnt + 1'b1;
  end

  assign if_stall  = if_req & ~if_ack;
  assign d_stall   = d_pend & ~d_ack;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      if_ack         <= 1'b0;
      d_ack          <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      last_grant     <= 1'b1;
      wait_cnt       <= '0;
      proto_err      <= 1'b0;
      timeout        <= 1'b0;
      fetch_sel      <= 1'b1;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (grant_data) begin
            state          <= DATA;
            fetch_sel      <= 1'b0;
            mem_address    <= d_addr;
            mem_byteenable <= d_byteenable;
            mem_writedata  <= d_wdata;
            mem_write      <= d_write;
            mem_read       <= ~d_write;
            if (d_read && d_write) proto_err <= 1'b1;
          end else if (if_req) begin
            state          <= FETCH;
            fetch_sel      <= 1'b1;
            mem_address    <= if_addr;
            mem_byteenable <= 4'hF;
            mem_write      <= 1'b0;
            mem_read       <= 1'b1;
          end
        end
        FETCH, DATA: begin
          if (!mem_waitrequest) begin
            state      <= IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            last_grant <= fetch_sel;
            if (state == FETCH) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_readdata;
            end else begin
              d_ack <= 1'b1;
              if (!mem_write) d_rdata <= mem_readdata;
            end
          end else begin
            // Timeout is only a flag; the transaction keeps waiting.
            wait_cnt <= wait_nxt;
            if (32'(wait_nxt) >= TIMEOUT_CYCLES) timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Randomized bench for pipe_mem_arbiter: requesters and memory slave are
// modelled here, and a transaction-level reference predicts every output.
module tb_pipe_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_read, d_write;
  logic [31:0] d_addr;
  logic [3:0]  d_byteenable;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        fetch_sel, if_stall, d_stall, proto_err, timeout;
  logic [1:0]  fsm_state;

  pipe_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_byteenable(d_byteenable), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .fetch_sel(fetch_sel), .if_stall(if_stall), .d_stall(d_stall),
    .proto_err(proto_err), .timeout(timeout), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        fetch;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        cur;
  bit          has_cur, new_grant, last_fetch;
  bit          exp_if_ack, exp_d_ack, exp_perr, exp_tmo;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  int          cur_waits;

  // scoreboard: addresses issued by each requester, in order
  logic [31:0] exp_q[$];
  logic [31:0] dexp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    has_cur = 0; new_grant = 0; last_fetch = 1;
    exp_if_ack = 0; exp_d_ack = 0; exp_perr = 0; exp_tmo = 0;
    exp_if_rdata = '0; exp_d_rdata = '0; cur_waits = 0;
  endtask

  // Applies the arbitration rules for one rising edge.
  task automatic model_step();
    bit dp, fp;
    exp_if_ack = 0; exp_d_ack = 0; new_grant = 0;
    if (!has_cur) begin
      dp = d_read | d_write;
      fp = if_req;
      if (dp || fp) begin
        cur.fetch = (dp && fp) ? !last_fetch : fp;
        if (cur.fetch) begin
          cur.addr = if_addr; cur.be = 4'hF; cur.wr = 0; cur.wdata = '0;
        end else begin
          cur.addr = d_addr; cur.be = d_byteenable; cur.wr = d_write; cur.wdata = d_wdata;
          if (d_read && d_write) exp_perr = 1;
        end
        has_cur = 1; cur_waits = 0; new_grant = 1;
      end
    end else if (!mem_waitrequest) begin
      if (cur.fetch) begin
        exp_if_ack = 1; exp_if_rdata = mem_readdata;
      end else begin
        exp_d_ack = 1;
        if (!cur.wr) exp_d_rdata = mem_readdata;
      end
      last_fetch = cur.fetch;
      has_cur = 0;
    end else begin
      cur_waits++;
      if (cur_waits >= TMO) exp_tmo = 1;
    end
  endtask

  task automatic check_outputs();
    check("mem_read",  mem_read,  has_cur && !cur.wr);
    check("mem_write", mem_write, has_cur && cur.wr);
    if (has_cur) begin
      check("mem_address", mem_address, cur.addr);
      check("mem_be", mem_byteenable, cur.be);
      if (cur.wr) check("mem_wdata", mem_writedata, cur.wdata);
    end
    check("fetch_sel", fetch_sel, has_cur ? cur.fetch : last_fetch);
    check("if_ack", if_ack, exp_if_ack);
    check("d_ack", d_ack, exp_d_ack);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    check("proto_err", proto_err, exp_perr);
    check("timeout", timeout, exp_tmo);
    check("if_stall", if_stall, if_req & ~exp_if_ack);
    check("d_stall", d_stall, (d_read | d_write) & ~exp_d_ack);
    if (new_grant) begin
      if (cur.fetch) begin
        check("fetch_q_depth", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("fetch_addr_order", mem_address, exp_q.pop_front());
      end else begin
        check("data_q_depth", dexp_q.size() != 0, 1);
        if (dexp_q.size() != 0) check("data_addr_order", mem_address, dexp_q.pop_front());
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  bit d_hold, d_dropped, f_hold, f_dropped;
  int wr_run;

  task automatic issue_data(input bit writes_only);
    int k;
    logic [31:0] r;
    r = $urandom;
    d_addr = r & 32'hFFFF_FFFC;
    d_byteenable = 4'($urandom_range(0, 15));
    d_wdata = $urandom;
    k = $urandom_range(0, 15);
    if (writes_only)  begin d_read = 0; d_write = 1; end
    else if (k == 0)  begin d_read = 1; d_write = 1; end
    else if (k < 8)   begin d_read = 1; d_write = 0; end
    else              begin d_read = 0; d_write = 1; end
    d_hold = 1; d_dropped = 0;
    dexp_q.push_back(d_addr);
  endtask

  task automatic issue_fetch();
    logic [31:0] r;
    r = $urandom;
    if_addr = r & 32'hFFFF_FFFC;
    if_req = 1; f_hold = 1; f_dropped = 0;
    exp_q.push_back(if_addr);
  endtask

  task automatic drive_inputs(input bit long_waits, input bit writes_only);
    int max_run;
    if (exp_d_ack) begin d_hold = 0; d_dropped = 0; end
    if (d_hold && !d_dropped && has_cur && !cur.fetch && $urandom_range(0, 3) == 0) begin
      d_read = 0; d_write = 0; d_dropped = 1;
    end else if (!d_hold) begin
      if ($urandom_range(0, 1) == 1) issue_data(writes_only);
      else begin d_read = 0; d_write = 0; end
    end
    if (exp_if_ack) begin f_hold = 0; f_dropped = 0; end
    if (f_hold && !f_dropped && has_cur && cur.fetch && $urandom_range(0, 3) == 0) begin
      if_req = 0; f_dropped = 1;
    end else if (!f_hold) begin
      if ($urandom_range(0, 1) == 1) issue_fetch();
      else if_req = 0;
    end
    max_run = long_waits ? 6 : 3;
    if (wr_run < max_run && $urandom_range(0, long_waits ? 1 : 2) == 0) mem_waitrequest = 1;
    else mem_waitrequest = 0;
    wr_run = mem_waitrequest ? wr_run + 1 : 0;
    mem_readdata = $urandom;
  endtask

  task automatic step_cycle(input bit long_waits, input bit writes_only);
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    check_outputs();
    drive_inputs(long_waits, writes_only);
  endtask

  // ---------------- main sequence ----------------
  bit found;

  initial begin
    reset_n = 0;
    if_req = 0; if_addr = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_byteenable = '0; d_wdata = '0;
    mem_readdata = '0; mem_waitrequest = 0;
    d_hold = 0; d_dropped = 0; f_hold = 0; f_dropped = 0; wr_run = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_be", mem_byteenable, 4'h0);
    check("rst_mem_wdata", mem_writedata, 32'h0);
    check_outputs();
    reset_n = 1;

    repeat (500) step_cycle(0, 0);
    repeat (300) step_cycle(1, 0);

    // Reset while a data write is stalled on the bus.
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step_cycle(0, 1);
      if (has_cur && !cur.fetch) found = 1;
    end
    check("rst_target_found", found, 1);
    mem_waitrequest = 1;
    reset_n = 0;
    #1;
    check("async_mem_write", mem_write, 0);
    check("async_mem_read", mem_read, 0);
    check("async_d_ack", d_ack, 0);
    check("async_fetch_sel", fetch_sel, 1);
    check("async_proto_err", proto_err, 0);
    check("async_timeout", timeout, 0);
    model_reset();
    d_read = 0; d_write = 0; d_hold = 0; d_dropped = 0;
    exp_q.delete(); dexp_q.delete();
    if (f_hold && !f_dropped) exp_q.push_back(if_addr);
    else issue_fetch();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    check("rst_no_d_ack", d_ack, 0);
    mem_waitrequest = 0; wr_run = 0;
    reset_n = 1;

    repeat (150) step_cycle(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
